// File: rtl/keypad_matrix_scanner.sv
// Key matrix scanner. It drives an active-low rotating column strobe and samples the rows once per column slot.
// Whole frames are debounced, and each accepted press is emitted as one event over a valid/ready handshake.
module keypad_matrix_scanner #(
  parameter int N_COLS   = 4,
  parameter int N_ROWS   = 4,
  parameter int DIV      = 50000,
  parameter int DEBOUNCE = 4,
  localparam int CODE_W  = $clog2(N_ROWS * N_COLS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_ROWS-1:0] row_in,
  output logic [N_COLS-1:0] col_out,
  output logic              key_valid,
  output logic [CODE_W-1:0] key_code,
  input  logic              key_ready,
  output logic              key_held,
  output logic              overflow
);

  // Handshake: an event transfers on any edge where key_valid & key_ready.
  // While key_valid is high and not yet accepted, key_code holds steady.
  // A new event that arrives while a previous event is still pending is dropped and flagged on overflow.

  localparam int SLOT_W = $clog2(DIV);
  localparam int COL_W  = $clog2(N_COLS);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(DIV - 1);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(N_COLS - 1);
  localparam logic [3:0]        DEB       = 4'(DEBOUNCE);

  typedef enum logic [1:0] {IDLE, PRESS_CAND, PRESSED, REL_CAND} state_t;

  logic [N_ROWS-1:0] row_s1, row_s2;
  logic [SLOT_W-1:0] slot_cnt;
  logic [COL_W-1:0]  col_idx;
  logic [1:0]        hit_acc;
  logic [CODE_W-1:0] code_acc;

  state_t            state;
  logic [3:0]        deb_cnt;
  logic [CODE_W-1:0] cand;
  logic              evt;
  logic [CODE_W-1:0] evt_code;

  logic [1:0]        col_hits;
  logic [CODE_W-1:0] col_row;
  logic [CODE_W-1:0] col_code;
  logic [2:0]        hit_sum;
  logic [CODE_W-1:0] frame_code;
  logic [3:0]        deb_next;
  logic              sample, frame_end;
  logic              frame_none, frame_single, frame_multi;

  // Count the closed contacts on the strobed column. The count saturates at 2 because only 0, 1 and "many" matter.
  always_comb begin
    col_hits = 2'd0;
    col_row  = '0;
    for (int r = 0; r < N_ROWS; r++) begin
      if (!row_s2[r]) begin
        if (col_hits != 2'd2) col_hits = col_hits + 2'd1;
        col_row = CODE_W'(r);
      end
    end
  end

  assign col_code     = col_row * CODE_W'(N_COLS) + CODE_W'(col_idx);
  assign hit_sum      = {1'b0, hit_acc} + {1'b0, col_hits};
  assign sample       = (slot_cnt == SLOT_LAST);
  assign frame_end    = sample && (col_idx == COL_LAST);
  assign frame_none   = frame_end && (hit_sum == 3'd0);
  assign frame_single = frame_end && (hit_sum == 3'd1);
  assign frame_multi  = frame_end && (hit_sum >= 3'd2);
  assign frame_code   = (col_hits != 2'd0) ? col_code : code_acc;
  assign deb_next     = deb_cnt + 4'd1;

  // Scan timing, the column strobe and per-frame contact accumulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_s1   <= '1;
      row_s2   <= '1;
      slot_cnt <= '0;
      col_idx  <= '0;
      col_out  <= {{(N_COLS-1){1'b1}}, 1'b0};
      hit_acc  <= 2'd0;
      code_acc <= '0;
    end else begin
      row_s1 <= row_in;
      row_s2 <= row_s1;
      if (sample) begin
        slot_cnt <= '0;
        col_out  <= {col_out[N_COLS-2:0], col_out[N_COLS-1]};
        if (col_idx == COL_LAST) col_idx <= '0;
        else                     col_idx <= col_idx + COL_W'(1);
        if (frame_end) begin
          hit_acc  <= 2'd0;
          code_acc <= '0;
        end else begin
          hit_acc <= (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
          if (col_hits == 2'd1) code_acc <= col_code;
        end
      end else begin
        slot_cnt <= slot_cnt + SLOT_W'(1);
      end
    end
  end

  // Debounce FSM. It advances only at frame end. A ghosting (multi-contact) frame keeps the state and clears the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      deb_cnt  <= 4'd0;
      cand     <= '0;
      key_held <= 1'b0;
      evt      <= 1'b0;
      evt_code <= '0;
    end else begin
      evt <= 1'b0;
      if (frame_multi) begin
        deb_cnt <= 4'd0;
      end else if (frame_end) begin
        case (state)
          IDLE: begin
            if (frame_single) begin
              cand <= frame_code;
              if (DEB == 4'd1) begin
                state    <= PRESSED;
                key_held <= 1'b1;
                evt      <= 1'b1;
                evt_code <= frame_code;
                deb_cnt  <= 4'd0;
              end else begin
                state   <= PRESS_CAND;
                deb_cnt <= 4'd1;
              end
            end
          end
          PRESS_CAND: begin
            if (frame_none) begin
              state   <= IDLE;
              deb_cnt <= 4'd0;
            end else if (frame_code != cand) begin
              cand    <= frame_code;
              deb_cnt <= 4'd1;
            end else if (deb_next >= DEB) begin
              state    <= PRESSED;
              key_held <= 1'b1;
              evt      <= 1'b1;
              evt_code <= cand;
              deb_cnt  <= 4'd0;
            end else begin
              deb_cnt <= deb_next;
            end
          end
          PRESSED: begin
            // A different key stays ignored until this key has been released.
            if (frame_none) begin
              if (DEB == 4'd1) begin
                state    <= IDLE;
                key_held <= 1'b0;
                deb_cnt  <= 4'd0;
              end else begin
                state   <= REL_CAND;
                deb_cnt <= 4'd1;
              end
            end
          end
          REL_CAND: begin
            if (frame_none) begin
              if (deb_next >= DEB) begin
                state    <= IDLE;
                key_held <= 1'b0;
                deb_cnt  <= 4'd0;
              end else begin
                deb_cnt <= deb_next;
              end
            end else if (frame_code == cand) begin
              state   <= PRESSED;
              deb_cnt <= 4'd0;
            end else begin
              state    <= PRESS_CAND;
              cand     <= frame_code;
              key_held <= 1'b0;
              deb_cnt  <= 4'd1;
            end
          end
          default: begin
            state   <= IDLE;
            deb_cnt <= 4'd0;
          end
        endcase
      end
    end
  end

  // Output event register. A press that arrives in the same cycle the pending event is accepted takes over the slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_valid <= 1'b0;
      key_code  <= '0;
      overflow  <= 1'b0;
    end else begin
      overflow <= 1'b0;
      if (evt) begin
        if (!key_valid || key_ready) begin
          key_valid <= 1'b1;
          key_code  <= evt_code;
        end else begin
          overflow <= 1'b1;
        end
      end else if (key_valid && key_ready) begin
        key_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Bench for keypad_matrix_scanner: a 4x4 matrix with DIV=4 and DEBOUNCE=3, so each frame is 16 cycles.
// A key model drives the rows from the strobe, and a scoreboard checks press codes in the order they are accepted.
module tb_keypad_matrix_scanner;

  localparam int N_COLS = 4;
  localparam int N_ROWS = 4;
  localparam int DIV    = 4;
  localparam int DEB    = 3;
  localparam int FRAME  = N_COLS * DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_ready = 1'b1;
  logic       key_held;
  logic       overflow;
  logic [15:0] keys = '0;

  int checks   = 0;
  int failures = 0;
  int ovf_seen = 0;
  logic [3:0] exp_q[$];

  keypad_matrix_scanner #(
    .N_COLS(N_COLS), .N_ROWS(N_ROWS), .DIV(DIV), .DEBOUNCE(DEB)
  ) dut (
    .clk(clk), .rst(rst), .row_in(row_in), .col_out(col_out),
    .key_valid(key_valid), .key_code(key_code), .key_ready(key_ready),
    .key_held(key_held), .overflow(overflow)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Key matrix: a closed key pulls its row low while its column is strobed.
  always_comb begin
    row_in = '1;
    for (int r = 0; r < N_ROWS; r++)
      for (int c = 0; c < N_COLS; c++)
        if (keys[r*N_COLS + c] && !col_out[c]) row_in[r] = 1'b0;
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frames(input int n);
    edges(n * FRAME);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    edges(1);
    rst = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_col_out"}, col_out, 4'b1110);
    check({tag, "_key_valid"}, key_valid, 0);
    check({tag, "_key_code"}, key_code, 0);
    check({tag, "_key_held"}, key_held, 0);
    check({tag, "_overflow"}, overflow, 0);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [3:0] e;
    if (!rst) begin
      if (overflow) ovf_seen++;
      if (key_valid && key_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_event actual=%0d required=none at %0t", key_code, $time);
        end else begin
          e = exp_q.pop_front();
          check("event_code", key_code, e);
        end
      end
    end
  end

  initial begin
    logic [3:0] exp_col;
    edges(2);
    do_reset();
    check_reset_outputs("reset");

    // Idle strobe: one column per 4 cycles, period 16
    for (int i = 1; i <= 2 * FRAME; i++) begin
      edges(1);
      exp_col = ~(4'b0001 << ((i / DIV) % N_COLS));
      check("strobe", col_out, exp_col);
    end
    check("idle_valid", key_valid, 0);
    check("idle_held", key_held, 0);

    // Clean press of key 6 (row 1, col 2)
    exp_q.push_back(4'd6);
    keys = 16'h1 << 6;
    frames(2);
    check("press_held_early", key_held, 0);
    frames(1);
    check("press_held", key_held, 1);
    keys = '0;
    frames(2);
    check("release_held_early", key_held, 1);
    frames(1);
    check("release_held", key_held, 0);

    // Bounce between keys 1 and 6, then steady 6
    for (int k = 0; k < 6; k++) begin
      keys = (k % 2 == 0) ? (16'h1 << 6) : (16'h1 << 1);
      frames(1);
    end
    check("bounce_held", key_held, 0);
    exp_q.push_back(4'd6);
    keys = 16'h1 << 6;
    frames(2);
    check("bounce_steady_early", key_held, 0);
    frames(1);
    check("bounce_steady_held", key_held, 1);
    keys = '0;
    frames(3);
    check("bounce_release", key_held, 0);

    // Ghosting: keys 0 and 5 together, then key 0 alone
    keys = (16'h1 << 0) | (16'h1 << 5);
    frames(5);
    check("ghost_held", key_held, 0);
    check("ghost_valid", key_valid, 0);
    exp_q.push_back(4'd0);
    keys = 16'h1 << 0;
    frames(2);
    check("ghost_single_early", key_held, 0);
    frames(1);
    check("ghost_single_held", key_held, 1);
    keys = '0;
    frames(3);
    check("ghost_release", key_held, 0);

    // Backpressure: the pending 6 must survive a dropped press of 9
    key_ready = 1'b0;
    ovf_seen  = 0;
    exp_q.push_back(4'd6);
    keys = 16'h1 << 6;
    frames(3);
    check("bp_held6", key_held, 1);
    keys = '0;
    frames(3);
    check("bp_valid_pending", key_valid, 1);
    check("bp_code_pending", key_code, 6);
    keys = 16'h1 << 9;
    frames(3);
    check("bp_held9", key_held, 1);
    edges(2);
    check("bp_overflow_pulses", ovf_seen, 1);
    check("bp_code_kept", key_code, 6);
    check("bp_valid_kept", key_valid, 1);
    key_ready = 1'b1;
    edges(1);
    key_ready = 1'b0;
    check("bp_valid_dropped", key_valid, 0);
    edges(FRAME - 3);
    keys = '0;
    frames(3);
    check("bp_release", key_held, 0);
    key_ready = 1'b1;

    // Reset during PRESS_CAND with count 2
    keys = 16'h1 << 6;
    frames(2);
    do_reset();
    check_reset_outputs("midreset");
    keys = '0;
    frames(1);
    exp_q.push_back(4'd6);
    keys = 16'h1 << 6;
    frames(2);
    check("after_reset_early", key_held, 0);
    frames(1);
    check("after_reset_held", key_held, 1);
    keys = '0;
    frames(3);
    check("after_reset_release", key_held, 0);

    check("queue_drained", exp_q.size(), 0);
    check("overflow_total", ovf_seen, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
